// File: rtl/maq_ms.sv
// rtl/maq_ms.sv - seconds/minutes BCD timekeeping stage with 1 Hz prescaler and hour carry
module maq_ms #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pausa,
  input  logic       ajuste_min,
  input  logic       zera_seg,
  output logic       enable1hz,
  output logic       incrementa_hora,
  output logic [3:0] bcd_s_lsd,
  output logic [2:0] bcd_s_msd,
  output logic [3:0] bcd_m_lsd,
  output logic [2:0] bcd_m_msd
);

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_d;

  logic [3:0] s_lsd_d;
  logic [2:0] s_msd_d;
  logic [3:0] m_lsd_d;
  logic [2:0] m_msd_d;

  logic s_last;
  logic m_last;
  logic sec_wrap;
  logic min_step;

  // Advance a 00..59 BCD pair by one, wrapping 59 to 00; result is {msd, lsd}.
  function automatic logic [6:0] bcd60_inc(input logic [2:0] msd, input logic [3:0] lsd);
    logic [2:0] n_msd;
    logic [3:0] n_lsd;
    n_msd = msd;
    n_lsd = lsd + 4'd1;
    if (lsd == 4'd9) begin
      n_lsd = 4'd0;
      n_msd = (msd == 3'd5) ? 3'd0 : (msd + 3'd1);
    end
    return {n_msd, n_lsd};
  endfunction

  // Prescaler: zera_seg restarts the period, pausa freezes it, terminal count emits a tick.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (zera_seg) begin
      presc_d = '0;
    end else if (!pausa) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end
  end

  // Time next-state: the registered tick advances seconds; zera_seg overrides it and also
  // suppresses the minute carry, while ajuste_min merges with any carry into a single step.
  always_comb begin
    s_last   = (bcd_s_lsd == 4'd9) && (bcd_s_msd == 3'd5);
    m_last   = (bcd_m_lsd == 4'd9) && (bcd_m_msd == 3'd5);
    sec_wrap = enable1hz && s_last && !zera_seg;
    min_step = ajuste_min || sec_wrap;

    s_lsd_d = bcd_s_lsd;
    s_msd_d = bcd_s_msd;
    m_lsd_d = bcd_m_lsd;
    m_msd_d = bcd_m_msd;

    if (zera_seg) begin
      s_lsd_d = 4'd0;
      s_msd_d = 3'd0;
    end else if (enable1hz) begin
      {s_msd_d, s_lsd_d} = bcd60_inc(bcd_s_msd, bcd_s_lsd);
    end

    if (min_step) begin
      {m_msd_d, m_lsd_d} = bcd60_inc(bcd_m_msd, bcd_m_lsd);
    end
  end

  // Hour carry is a pure decode of the current count so it spans the entire 59:59 second.
  always_comb begin
    incrementa_hora = s_last && m_last;
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      enable1hz <= 1'b0;
      bcd_s_lsd <= 4'd0;
      bcd_s_msd <= 3'd0;
      bcd_m_lsd <= 4'd0;
      bcd_m_msd <= 3'd0;
    end else begin
      presc_q   <= presc_d;
      enable1hz <= tick_d;
      bcd_s_lsd <= s_lsd_d;
      bcd_s_msd <= s_msd_d;
      bcd_m_lsd <= m_lsd_d;
      bcd_m_msd <= m_msd_d;
    end
  end

endmodule

// File: tb/tb_maq_ms.sv
// tb/tb_maq_ms.sv - directed self-checking bench for maq_ms with CLK_HZ=4
module tb_maq_ms;

  logic       clock;
  logic       reset;
  logic       pausa;
  logic       ajuste_min;
  logic       zera_seg;
  logic       enable1hz;
  logic       incrementa_hora;
  logic [3:0] bcd_s_lsd;
  logic [2:0] bcd_s_msd;
  logic [3:0] bcd_m_lsd;
  logic [2:0] bcd_m_msd;

  int n_tests;
  int n_fail;
  int exp_mm;

  maq_ms #(.CLK_HZ(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .pausa           (pausa),
    .ajuste_min      (ajuste_min),
    .zera_seg        (zera_seg),
    .enable1hz       (enable1hz),
    .incrementa_hora (incrementa_hora),
    .bcd_s_lsd       (bcd_s_lsd),
    .bcd_s_msd       (bcd_s_msd),
    .bcd_m_lsd       (bcd_m_lsd),
    .bcd_m_msd       (bcd_m_msd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tval();
    return int'(bcd_m_msd) * 1000 + int'(bcd_m_lsd) * 100 + int'(bcd_s_msd) * 10 + int'(bcd_s_lsd);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_tick();
    int b;
    b = 0;
    while (!enable1hz && b < 20) begin
      step();
      b++;
    end
    if (!enable1hz) check("tick_timeout", int'(enable1hz), 1);
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      wait_tick();
      step();
    end
  endtask

  task automatic pulse_zera();
    zera_seg = 1'b1;
    step();
    zera_seg = 1'b0;
  endtask

  task automatic pulse_ajuste();
    ajuste_min = 1'b1;
    step();
    ajuste_min = 1'b0;
  endtask

  task automatic goto(input int mm, input int ss);
    int n;
    pulse_zera();
    n = (mm - exp_mm + 60) % 60;
    repeat (n) pulse_ajuste();
    exp_mm = mm;
    pulse_zera();
    advance(ss);
    check("goto", tval(), mm * 100 + ss);
  endtask

  initial begin
    int cnt;
    n_tests    = 0;
    n_fail     = 0;
    exp_mm     = 0;
    reset      = 1'b0;
    pausa      = 1'b0;
    ajuste_min = 1'b0;
    zera_seg   = 1'b0;

    // Reset state
    step();
    step();
    check("rst_en", int'(enable1hz), 0);
    check("rst_time", tval(), 0);
    check("rst_ih", int'(incrementa_hora), 0);

    // Release reset, first ticks after edges 4 and 8, 00:01 after edge 5
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("first_tick_e%0d", k), int'(enable1hz), (k % 4 == 0) ? 1 : 0);
      if (k == 4) check("time_e4", tval(), 0);
      if (k == 5) check("time_e5", tval(), 1);
    end

    // BCD rollovers
    advance(8);
    check("to_0009", tval(), 9);
    advance(1);
    check("roll_0010", tval(), 10);
    advance(49);
    check("at_0059", tval(), 59);
    advance(1);
    check("roll_0100", tval(), 100);
    exp_mm = 1;
    goto(9, 59);
    advance(1);
    check("roll_1000", tval(), 1000);
    exp_mm = 10;

    // Hour carry
    goto(59, 58);
    check("ih_5958", int'(incrementa_hora), 0);
    advance(1);
    check("ih_5959", int'(incrementa_hora), 1);
    wait_tick();
    check("ih_with_tick", int'(incrementa_hora), 1);
    check("tick_at_5959", int'(enable1hz), 1);
    step();
    check("wrap_0000", tval(), 0);
    check("ih_after_wrap", int'(incrementa_hora), 0);
    exp_mm = 0;

    // Minute set
    goto(59, 30);
    check("ih_pre_adj", int'(incrementa_hora), 0);
    pulse_ajuste();
    check("adj_0030", tval(), 30);
    check("ih_post_adj", int'(incrementa_hora), 0);
    exp_mm = 0;
    goto(12, 59);
    wait_tick();
    pulse_ajuste();
    check("adj_tick_1300", tval(), 1300);
    exp_mm = 13;

    // Second clear coincident with tick
    goto(7, 59);
    wait_tick();
    pulse_zera();
    check("zera_0700", tval(), 700);
    check("zera_en", int'(enable1hz), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("zera_next_tick_e%0d", k), int'(enable1hz), (k == 4) ? 1 : 0);
    end
    step();
    check("zera_0701", tval(), 701);

    // Pause mid-period: tick delayed by exactly 10 cycles
    step();
    pausa = 1'b1;
    cnt = 0;
    while (!enable1hz && cnt < 40) begin
      step();
      cnt++;
      if (cnt == 10) pausa = 1'b0;
    end
    check("pause_delay", cnt, 12);

    // Pause raised while the tick is already out still lets it count
    pausa = 1'b1;
    step();
    check("pause_tick_0702", tval(), 702);
    check("pause_no_tick", int'(enable1hz), 0);
    pausa = 1'b0;

    // Asynchronous reset between edges
    goto(34, 21);
    #3;
    reset = 1'b0;
    #1;
    check("async_time", tval(), 0);
    check("async_en", int'(enable1hz), 0);
    check("async_ih", int'(incrementa_hora), 0);
    step();
    check("held_time", tval(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
